// File: rtl/i2c_target.sv
// I2C target responder: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// and a byte register file with an auto-incrementing, wrapping pointer.
// SDA is open-drain: sda_oe=1 pulls the line low.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_byte,
  output logic             busy
);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StAckAddr, StRegPtr, StAckPtr, StWrData, StAckWr, StRdData, StRdAck
  } state_e;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [7:0]       sh_q;
  logic             rw_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       regs_q [DEPTH];
  logic             sda_oe_q, wr_strobe_q, busy_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [7:0]       wr_byte_q;

  logic scl_hi, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rd_byte;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b0;
      scl_s2_q <= 1'b0;
      scl_h_q  <= 1'b0;
      sda_s1_q <= 1'b0;
      sda_s2_q <= 1'b0;
      sda_h_q  <= 1'b0;
    end else begin
      scl_s1_q <= scl_in;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  // Bus events derived from the synchronized samples and their history.
  always_comb begin
    scl_hi    = scl_s2_q & scl_h_q;
    scl_rise  = scl_s2_q & ~scl_h_q;
    scl_fall  = ~scl_s2_q & scl_h_q;
    start_det = scl_hi & sda_h_q & ~sda_s2_q;
    stop_det  = scl_hi & ~sda_h_q & sda_s2_q;
    rd_byte   = regs_q[ptr_q];
  end

  // Protocol state machine; all outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      regs_q      <= '{default: '0};
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_ptr_q    <= '0;
      wr_byte_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_det) begin
        // Also a repeated START: any partial byte is dropped.
        state_q  <= StDevAddr;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StDevAddr, StRegPtr, StWrData: begin
            if (scl_rise) begin
              sh_q  <= {sh_q[6:0], sda_s2_q};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q <= '0;
              if (state_q == StDevAddr) begin
                if (sh_q[7:1] == DEV_ADDR) begin
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  rw_q     <= sh_q[0];
                  state_q  <= StAckAddr;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
                end
              end else if (state_q == StRegPtr) begin
                ptr_q    <= sh_q[PTR_W-1:0];
                sda_oe_q <= 1'b1;
                state_q  <= StAckPtr;
              end else begin
                regs_q[ptr_q] <= sh_q;
                wr_strobe_q   <= 1'b1;
                wr_ptr_q      <= ptr_q;
                wr_byte_q     <= sh_q;
                sda_oe_q      <= 1'b1;
                ptr_q         <= ptr_q + 1'b1;
                state_q       <= StAckWr;
              end
            end
          end
          StAckAddr: begin
            if (scl_fall) begin
              if (rw_q) begin
                // MSB goes out now; cnt_q counts bits already placed on the bus.
                sh_q     <= {rd_byte[6:0], 1'b0};
                sda_oe_q <= ~rd_byte[7];
                cnt_q    <= 4'd1;
                state_q  <= StRdData;
              end else begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                state_q  <= StRegPtr;
              end
            end
          end
          StAckPtr, StAckWr: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= StWrData;
            end
          end
          StRdData: begin
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                ptr_q    <= ptr_q + 1'b1;
                state_q  <= StRdAck;
              end else begin
                sda_oe_q <= ~sh_q[7];
                sh_q     <= {sh_q[6:0], 1'b0};
                cnt_q    <= cnt_q + 4'd1;
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              if (sda_s2_q) begin
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end
            end else if (scl_fall) begin
              sh_q     <= {rd_byte[6:0], 1'b0};
              sda_oe_q <= ~rd_byte[7];
              cnt_q    <= 4'd1;
              state_q  <= StRdData;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_ptr    = wr_ptr_q;
  assign wr_byte   = wr_byte_q;
  assign busy      = busy_q;

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder: the far end of the controller-side write/read tasks in i2c_pkg.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit device address.
- Serves an internal byte register file with an auto-incrementing pointer.
- Sits at the chip pad boundary; SDA is open-drain, modelled as sda_in plus a pull-low enable.

Parameters:
- DEV_ADDR, 7'h50: 7-bit device address this target answers to.
- DEPTH, 16: number of 8-bit registers. Must be a power of 2, at most 256.
- PTR_W, $clog2(DEPTH): register pointer width.

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  SCL pad input, asynchronous to clk.
- sda_in  in  1  SDA pad input, asynchronous to clk.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- wr_strobe  out  1  one-cycle pulse when a data byte is committed to the register file.
- wr_ptr  out  PTR_W  register index written; valid with wr_strobe.
- wr_byte  out  8  data written; valid with wr_strobe.
- busy  out  1  high from an address-matched START until STOP or NACK.

Behaviour:
- Reset (rst=1 at a clk edge): sda_oe=0, wr_strobe=0, wr_ptr=0, wr_byte=0, busy=0, pointer=0, state=IDLE. All registers cleared to 0.
- Input sampling: 2-FF synchronizer on scl_in and sda_in, then one history FF for edge detection. Events are seen 3 clk cycles after a pad change.
- START: synchronized SDA falls while SCL is high. Valid in any state, including repeated START; always moves to DEV_ADDR with the bit count cleared.
- STOP: synchronized SDA rises while SCL is high. From any state: go to IDLE, sda_oe=0, busy=0.
- Data bits are sampled on the SCL rising edge, MSB first. The target changes sda_oe only on the clk cycle after an SCL falling edge is detected.
- State machine:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits (7-bit address + R/W).
    - On the 8th SCL fall: if addr==DEV_ADDR, assert sda_oe (ACK), set busy, go to ACK_ADDR.
    - On mismatch: keep sda_oe=0 (NACK) and go to IDLE; a later START or STOP is still tracked.
  - ACK_ADDR: on the next SCL fall, release the ACK.
    - If R/W=0, go to REG_PTR.
    - If R/W=1, go to RD_DATA and drive bit 7 of reg[pointer] immediately (sda_oe = ~bit).
  - REG_PTR: shift 8 bits. On the 8th SCL fall: pointer = byte[PTR_W-1:0] (upper bits ignored), assert ACK, go to ACK_PTR.
  - ACK_PTR: on SCL fall, release ACK, go to WR_DATA.
  - WR_DATA: shift 8 bits. On the 8th SCL fall:
    - write reg[pointer];
    - pulse wr_strobe with wr_ptr=pointer, wr_byte=data;
    - assert ACK, increment pointer, go to ACK_WR.
  - ACK_WR: on SCL fall, release ACK, go to WR_DATA.
  - RD_DATA: shift reg[pointer] out MSB first (sda_oe = ~bit, updated on each SCL fall). After the 8th bit's SCL fall, release SDA, increment pointer, go to RD_ACK.
  - RD_ACK: sample the controller's bit on SCL rise.
    - 0 (ACK): on the next SCL fall, load the next byte and drive its MSB; go to RD_DATA.
    - 1 (NACK): release SDA, clear busy, go to IDLE.
- Pointer wraps modulo DEPTH: DEPTH-1 increments to 0.
- Repeated START after REG_PTR keeps the pointer; this gives the standard combined write-pointer/read format.
- A START or STOP mid-byte discards the partial byte. No register write and no wr_strobe.
- rst asserted mid-transfer: immediate return to reset values, SDA released on the same edge.
- The target never stretches SCL.

Test Plan:
- Write: START, 0xA0 (0x50,W), 0x03, 0xA5, STOP -> ACK on all three bytes; wr_strobe once with wr_ptr=3, wr_byte=0xA5; reg[3]=0xA5; busy low after STOP.
- Combined read: write pointer 0x03, repeated START, 0xA1, controller NACKs after one byte -> SDA carries 0xA5; sda_oe=0 after NACK; busy=0.
- Address mismatch: START, 0xB0 -> no ACK (sda_oe stays 0 through the 9th clock); no wr_strobe; state IDLE.
- Wrap: pointer 0x0F, write 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22; wr_ptr sequence 15 then 0.
- Burst read: pointer 0x0E, read 3 bytes with ACK, ACK, NACK -> bytes returned are reg[14], reg[15], reg[0].
- Reset mid-byte: rst pulsed after 4 data bits of a write -> sda_oe=0, busy=0, no wr_strobe, all registers 0. Next full transaction succeeds.
